// File: rtl/bp_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bp_pkg: shared defaults for branch_predictor_table.  Rev 1.0     |
// +------------------------------------------------------------------+
package bp_pkg;
  localparam int c_ctr_w_def  = 2;
  localparam int c_idx_w_def  = 4;
  localparam int c_hist_w_def = 4;
  localparam int c_gshare_def = 1;
  localparam int c_miss_cnt_w = 16;
endpackage : bp_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sat_counter: one predictor entry, saturating up/down counter.    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module sat_counter #(
  parameter int CTR_W    = 2,
  parameter int CTR_INIT = 2**(CTR_W-1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc_i,
  input  logic dec_i,
  output logic msb_o
);

  localparam logic [CTR_W-1:0] c_max = '1;

  logic [CTR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != c_max)) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= CTR_W'(CTR_INIT);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign msb_o = cnt_q[CTR_W-1];

endmodule : sat_counter
`default_nettype wire

// File: rtl/branch_predictor_table.sv
`default_nettype none
// +------------------------------------------------------------------+
// | branch_predictor_table: gshare/bimodal direction predictor with  |
// | 1-cycle prediction latency and a mispredict counter.  Rev 1.0    |
// +------------------------------------------------------------------+
module branch_predictor_table
  import bp_pkg::*;
#(
  parameter int CTR_W    = c_ctr_w_def,
  parameter int IDX_W    = c_idx_w_def,
  parameter int HIST_W   = c_hist_w_def,
  parameter int GSHARE   = c_gshare_def,
  parameter int CTR_INIT = 2**(CTR_W-1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  input  logic [IDX_W-1:0]        req_pc,
  output logic                    pred_valid,
  output logic                    pred_taken,
  output logic [IDX_W-1:0]        pred_idx,
  input  logic                    upd_valid,
  input  logic [IDX_W-1:0]        upd_idx,
  input  logic                    upd_taken,
  output logic [c_miss_cnt_w-1:0] mispredict_cnt
);

  localparam int c_entries = 2**IDX_W;
  // History kept at least one bit wide; it stays zero when HIST_W is 0.
  localparam int c_hw = (HIST_W > 0) ? HIST_W : 1;

  logic [c_entries-1:0]    w_msb;
  logic [IDX_W-1:0]        w_req_idx;
  logic [c_hw-1:0]         w_hist_shift;
  logic [c_hw-1:0]         hist_q, hist_d;
  logic [c_miss_cnt_w-1:0] miss_q, miss_d;
  logic                    pred_valid_q;
  logic                    pred_taken_q, pred_taken_d;
  logic [IDX_W-1:0]        pred_idx_q, pred_idx_d;

  generate
    for (genvar i = 0; i < c_entries; i++) begin : g_tbl
      sat_counter #(
        .CTR_W    (CTR_W),
        .CTR_INIT (CTR_INIT)
      ) u_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (upd_valid && (upd_idx == IDX_W'(i)) && upd_taken),
        .dec_i (upd_valid && (upd_idx == IDX_W'(i)) && !upd_taken),
        .msb_o (w_msb[i])
      );
    end

    if ((GSHARE != 0) && (HIST_W > 0)) begin : g_gshare
      assign w_req_idx = req_pc ^ IDX_W'(hist_q);
    end else begin : g_bimodal
      assign w_req_idx = req_pc;
    end

    if (c_hw == 1) begin : g_hist_one
      assign w_hist_shift = upd_taken;
    end else begin : g_hist_many
      assign w_hist_shift = {hist_q[c_hw-2:0], upd_taken};
    end
  endgenerate

  // Counters and history update on the same edge, so reads here are pre-update.
  always_comb begin
    hist_d       = hist_q;
    miss_d       = miss_q;
    pred_taken_d = pred_taken_q;
    pred_idx_d   = pred_idx_q;
    if (upd_valid) begin
      if (HIST_W > 0) begin
        hist_d = w_hist_shift;
      end
      if ((w_msb[upd_idx] != upd_taken) && (miss_q != '1)) begin
        miss_d = miss_q + 1'b1;
      end
    end
    if (req_valid) begin
      pred_taken_d = w_msb[w_req_idx];
      pred_idx_d   = w_req_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q       <= '0;
      miss_q       <= '0;
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      pred_idx_q   <= '0;
    end else begin
      hist_q       <= hist_d;
      miss_q       <= miss_d;
      pred_valid_q <= req_valid;
      pred_taken_q <= pred_taken_d;
      pred_idx_q   <= pred_idx_d;
    end
  end

  assign pred_valid     = pred_valid_q;
  assign pred_taken     = pred_taken_q;
  assign pred_idx       = pred_idx_q;
  assign mispredict_cnt = miss_q;

endmodule : branch_predictor_table
`default_nettype wire

// File: tb/tb_branch_predictor_table.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_branch_predictor_table: directed self-checking bench.         |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_branch_predictor_table;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic [3:0]  req_pc;
  logic        pred_valid;
  logic        pred_taken;
  logic [3:0]  pred_idx;
  logic        upd_valid;
  logic [3:0]  upd_idx;
  logic        upd_taken;
  logic [15:0] mispredict_cnt;

  int n_cmp = 0;
  int n_err = 0;

  branch_predictor_table dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_pc         (req_pc),
    .pred_valid     (pred_valid),
    .pred_taken     (pred_taken),
    .pred_idx       (pred_idx),
    .upd_valid      (upd_valid),
    .upd_idx        (upd_idx),
    .upd_taken      (upd_taken),
    .mispredict_cnt (mispredict_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cycle();
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    upd_valid = 1'b0;
  endtask

  task automatic do_update(input logic [3:0] idx, input logic tk);
    upd_valid = 1'b1;
    upd_idx   = idx;
    upd_taken = tk;
    cycle();
  endtask

  task automatic do_request(input logic [3:0] pc);
    req_valid = 1'b1;
    req_pc    = pc;
    cycle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; upd_valid = 1'b0;
    req_pc = 4'h0; upd_idx = 4'h0; upd_taken = 1'b0;
    #2;
    n_cmp++; if (pred_valid !== 1'b0) begin n_err++; $display("FAIL rst_pred_valid: got %b want 0", pred_valid); end
    n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL rst_pred_taken: got %b want 0", pred_taken); end
    n_cmp++; if (pred_idx !== 4'h0) begin n_err++; $display("FAIL rst_pred_idx: got %h want 0", pred_idx); end
    n_cmp++; if (mispredict_cnt !== 16'h0) begin n_err++; $display("FAIL rst_miss: got %h want 0", mispredict_cnt); end
    #10 rst_n = 1'b1;
    // First edge after release must accept the request.
    do_request(4'h3);
    n_cmp++; if (pred_valid !== 1'b1) begin n_err++; $display("FAIL first_req_valid: got %b want 1", pred_valid); end
    n_cmp++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL first_req_taken: got %b want 1", pred_taken); end
    n_cmp++; if (pred_idx !== 4'h3) begin n_err++; $display("FAIL first_req_idx: got %h want 3", pred_idx); end
    cycle();
    n_cmp++; if (pred_valid !== 1'b0) begin n_err++; $display("FAIL idle_valid: got %b want 0", pred_valid); end
    n_cmp++; if (pred_idx !== 4'h3 || pred_taken !== 1'b1) begin n_err++; $display("FAIL idle_hold: got idx %h tk %b want 3 1", pred_idx, pred_taken); end
  endtask

  task automatic test_saturate_down();
    do_update(4'h5, 1'b0);
    do_update(4'h5, 1'b0);
    do_update(4'h5, 1'b0);
    do_request(4'h5);
    n_cmp++; if (pred_idx !== 4'h5) begin n_err++; $display("FAIL down_idx: got %h want 5", pred_idx); end
    n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL down_taken: got %b want 0", pred_taken); end
    n_cmp++; if (mispredict_cnt !== 16'd1) begin n_err++; $display("FAIL down_miss: got %0d want 1", mispredict_cnt); end
    // One taken step from a saturated 0 gives 1, still not-taken.
    do_update(4'h5, 1'b1);
    do_request(4'h5 ^ 4'h1);
    n_cmp++; if (pred_idx !== 4'h5 || pred_taken !== 1'b0) begin n_err++; $display("FAIL down_nowrap: got idx %h tk %b want 5 0", pred_idx, pred_taken); end
    n_cmp++; if (mispredict_cnt !== 16'd2) begin n_err++; $display("FAIL down_miss2: got %0d want 2", mispredict_cnt); end
    // Restore history to zero: 4 not-taken updates on entry 4 (2->1 mispredicts once).
    for (int i = 0; i < 4; i++) do_update(4'h4, 1'b0);
    n_cmp++; if (mispredict_cnt !== 16'd3) begin n_err++; $display("FAIL down_miss3: got %0d want 3", mispredict_cnt); end
  endtask

  task automatic test_gshare();
    do_update(4'h0, 1'b1);
    do_update(4'h0, 1'b1);
    do_update(4'h0, 1'b0);
    do_request(4'hF);
    n_cmp++; if (pred_idx !== 4'h9) begin n_err++; $display("FAIL gshare_idx: got %h want 9", pred_idx); end
    n_cmp++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL gshare_taken: got %b want 1", pred_taken); end
    n_cmp++; if (mispredict_cnt !== 16'd4) begin n_err++; $display("FAIL gshare_miss: got %0d want 4", mispredict_cnt); end
  endtask

  task automatic test_same_cycle();
    // History 0110: pc 1 -> idx 7, entry 7 holds 2.
    req_valid = 1'b1; req_pc = 4'h1;
    upd_valid = 1'b1; upd_idx = 4'h7; upd_taken = 1'b0;
    cycle();
    n_cmp++; if (pred_idx !== 4'h7) begin n_err++; $display("FAIL same_idx: got %h want 7", pred_idx); end
    n_cmp++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL same_taken: got %b want 1", pred_taken); end
    n_cmp++; if (mispredict_cnt !== 16'd5) begin n_err++; $display("FAIL same_miss: got %0d want 5", mispredict_cnt); end
    // History 1100: pc B -> idx 7, entry now 1.
    do_request(4'hB);
    n_cmp++; if (pred_idx !== 4'h7 || pred_taken !== 1'b0) begin n_err++; $display("FAIL same_after: got idx %h tk %b want 7 0", pred_idx, pred_taken); end
    // Entry 1 -> 2 proves it was 1 rather than 0; history becomes 1001.
    do_update(4'h7, 1'b1);
    do_request(4'hE);
    n_cmp++; if (pred_idx !== 4'h7 || pred_taken !== 1'b1) begin n_err++; $display("FAIL same_value1: got idx %h tk %b want 7 1", pred_idx, pred_taken); end
    n_cmp++; if (mispredict_cnt !== 16'd6) begin n_err++; $display("FAIL same_miss2: got %0d want 6", mispredict_cnt); end
  endtask

  task automatic test_saturate_up();
    for (int i = 0; i < 5; i++) do_update(4'h3, 1'b1);
    n_cmp++; if (mispredict_cnt !== 16'd6) begin n_err++; $display("FAIL up_miss0: got %0d want 6", mispredict_cnt); end
    // 3 -> 2: still taken (a wrap would have left it low). History now 1110.
    do_update(4'h3, 1'b0);
    do_request(4'hD);
    n_cmp++; if (pred_idx !== 4'h3 || pred_taken !== 1'b1) begin n_err++; $display("FAIL up_sat: got idx %h tk %b want 3 1", pred_idx, pred_taken); end
    n_cmp++; if (mispredict_cnt !== 16'd7) begin n_err++; $display("FAIL up_miss1: got %0d want 7", mispredict_cnt); end
    // 2 -> 1; history 1100.
    do_update(4'h3, 1'b0);
    do_request(4'hF);
    n_cmp++; if (pred_idx !== 4'h3 || pred_taken !== 1'b0) begin n_err++; $display("FAIL up_step: got idx %h tk %b want 3 0", pred_idx, pred_taken); end
    n_cmp++; if (mispredict_cnt !== 16'd8) begin n_err++; $display("FAIL up_miss2: got %0d want 8", mispredict_cnt); end
  endtask

  task automatic test_back_to_back();
    // History 1100; consecutive requests while updating entry 0 (holds 2).
    req_valid = 1'b1; req_pc = 4'hC; upd_valid = 1'b1; upd_idx = 4'h0; upd_taken = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (pred_valid !== 1'b1 || pred_idx !== 4'h0 || pred_taken !== 1'b1) begin n_err++; $display("FAIL b2b_0: got v %b idx %h tk %b want 1 0 1", pred_valid, pred_idx, pred_taken); end
    // History now 1000; entry 0 now 1.
    req_pc = 4'h8; upd_idx = 4'h9; upd_taken = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (pred_valid !== 1'b1 || pred_idx !== 4'h0 || pred_taken !== 1'b0) begin n_err++; $display("FAIL b2b_1: got v %b idx %h tk %b want 1 0 0", pred_valid, pred_idx, pred_taken); end
    n_cmp++; if (mispredict_cnt !== 16'd9) begin n_err++; $display("FAIL b2b_miss: got %0d want 9", mispredict_cnt); end
    req_valid = 1'b0; upd_valid = 1'b0;
  endtask

  task automatic test_reset_midstream();
    // Keep a request and an update in flight while reset hits between edges.
    req_valid = 1'b1; req_pc = 4'h2; upd_valid = 1'b1; upd_idx = 4'h5; upd_taken = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (pred_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid: got %b want 0", pred_valid); end
    n_cmp++; if (mispredict_cnt !== 16'd0) begin n_err++; $display("FAIL mid_miss: got %0d want 0", mispredict_cnt); end
    n_cmp++; if (pred_idx !== 4'h0 || pred_taken !== 1'b0) begin n_err++; $display("FAIL mid_pred: got idx %h tk %b want 0 0", pred_idx, pred_taken); end
    @(posedge clk); #1;
    n_cmp++; if (pred_valid !== 1'b0) begin n_err++; $display("FAIL mid_hold: got %b want 0", pred_valid); end
    req_valid = 1'b0; upd_valid = 1'b0;
    #2 rst_n = 1'b1;
    // Zero history: pc maps straight through; entry 5 is back at 2.
    do_request(4'h5);
    n_cmp++; if (pred_valid !== 1'b1 || pred_idx !== 4'h5 || pred_taken !== 1'b1) begin n_err++; $display("FAIL mid_entry5: got v %b idx %h tk %b want 1 5 1", pred_valid, pred_idx, pred_taken); end
    do_request(4'h3);
    n_cmp++; if (pred_idx !== 4'h3 || pred_taken !== 1'b1) begin n_err++; $display("FAIL mid_entry3: got idx %h tk %b want 3 1", pred_idx, pred_taken); end
    do_request(4'h0);
    n_cmp++; if (pred_idx !== 4'h0 || pred_taken !== 1'b1) begin n_err++; $display("FAIL mid_entry0: got idx %h tk %b want 0 1", pred_idx, pred_taken); end
    n_cmp++; if (mispredict_cnt !== 16'd0) begin n_err++; $display("FAIL mid_miss_after: got %0d want 0", mispredict_cnt); end
  endtask

  initial begin
    test_reset();
    test_saturate_down();
    test_gshare();
    test_same_cycle();
    test_saturate_up();
    test_back_to_back();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_branch_predictor_table
`default_nettype wire
